keycode_event_queue: RTL
========================

# keycode_event_queue

Downstream consumer of the SoC's `keycode_export` and `button0_export` PIO lines.
- Converts the level-type USB keycode into discrete press/release events.
- Debounces the four raw pushbuttons and converts their edges into events.
- Queues all events in a small first-word-fall-through FIFO with a valid/ready handshake.
- Sits between the SoC and the game/control logic, so that logic never has to poll the keycode or filter button bounce.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button change (10 ms at 50 MHz). Minimum 2.
- `FIFO_DEPTH`, default 8: event queue entries. Must be a power of 2, ≥ 2.

Ports:
- `clk_clk` in 1: system clock, single clock domain.
- `reset_reset_n` in 1: reset, synchronous, active-low.
- `keycode` in 8: current keycode from the SoC; 0x00 means no key held. Synchronous to `clk_clk`.
- `button_n` in 4: raw pushbuttons, active-low (0 = pressed). Asynchronous.
- `ev_data` out 10: head event, `{type[1:0], code[7:0]}`.
  - type 00 = key press, 01 = key release, 10 = button press, 11 = button release.
  - For button events, code = button index 0–3, zero-extended.
- `ev_valid` out 1: FIFO not empty.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_count` out log2(FIFO_DEPTH)+1: current occupancy.
- `buttons_db` out 4: debounced button levels, 1 = pressed.
- `cur_key` out 8: last reported held keycode.
- `overflow` out 1: sticky. Set in any cycle where an event is pending and the FIFO is full.

## Operation
Button path:
- Invert `button_n` and pass it through a 2-FF synchronizer, giving `sync[i]`.
- Each button has a counter of width clog2(DEBOUNCE_CYCLES).
  - If `sync[i] == buttons_db[i]`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and `sync[i]` still differs, toggle `buttons_db[i]` and clear the counter.
- `rep[i]` is an internal register holding the last reported level of each button.

Event generator: at most one FIFO write per cycle, chosen by this priority:
1. `keycode != cur_key` and `cur_key != 0`: push release(`cur_key`), and `cur_key` ← 0.
2. `keycode != cur_key` and `cur_key == 0`: push press(`keycode`), and `cur_key` ← `keycode`.
3. Otherwise, take the lowest i with `buttons_db[i] != rep[i]`: push press(i) if `buttons_db[i]` = 1, else release(i); then `rep[i]` ← `buttons_db[i]`.
4. Otherwise, no push.

Generator rules:
- A key change A→B therefore yields release(A), then press(B) on the next cycle, provided `keycode` is still B.
- If the FIFO is full, no push occurs and `cur_key`/`rep` do not update. The event is deferred, not lost, and `overflow` is set.
  - Keycodes that appear and vanish while the FIFO is stalled are never reported.

FIFO:
- Circular buffer with read pointer, write pointer and count.
- `ev_data` is driven from the head entry (fall-through).
- Pop when `ev_valid && ev_ready`.
- Fullness is evaluated on the registered count. When full, a same-cycle pop does not admit a push; the push happens the following cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (`reset_reset_n` = 0 at a rising edge):
  - Pointers, count, `cur_key`, `rep`, `buttons_db`, debounce counters, synchronizers and `overflow` go to 0.
  - Outputs after reset: `ev_valid` = 0, `ev_count` = 0, `ev_data` = 0 (FIFO storage cleared), `buttons_db` = 0, `cur_key` = 0, `overflow` = 0.
  - Reset mid-operation discards all queued events. A key held through reset produces a press event on the first cycle after reset.
- Keycode latency: a `keycode` change sampled at edge n is written at edge n. `ev_valid` is high after edge n if the FIFO was empty.
- Button latency: a clean press becomes `buttons_db` = 1 exactly 2 + DEBOUNCE_CYCLES edges after `button_n` falls. The event is pushed on the next edge if no key event has priority and the FIFO is not full.
- Bounce shorter than DEBOUNCE_CYCLES: no change to `buttons_db`, no event.
- `ev_count` and `ev_valid` update one edge after a push or pop.
- `ev_data` changes only on a pop, or on a push into an empty FIFO.

## Test plan
Simulation uses `DEBOUNCE_CYCLES` = 4 and `FIFO_DEPTH` = 4.
1. Reset, then `keycode` 0x00→0x1A→0x00 with `ev_ready` = 1 → events {00,0x1A}, then {01,0x1A}; `cur_key` ends at 0; `overflow` = 0.
2. `keycode` 0x04→0x07 directly → release(0x04) then press(0x07) on consecutive cycles; no event dropped.
3. `button_n[2]` held low for 10 cycles with 1-cycle glitches before it → single press(2) (`ev_data` = 0x202), with `buttons_db[2]` rising 6 edges after the stable low; release produces `ev_data` = 0x302.
4. `ev_ready` = 0, then 6 distinct key toggles → `ev_count` saturates at 4 and `overflow` = 1. Raise `ev_ready` → the 4 queued events drain in order, then deferred events follow; no duplicates.
5. Key change and button change in the same cycle → the key event is queued first and the button event on the next cycle.
6. Assert reset while 3 events are queued and a key is held → `ev_count` = 0 at reset, then a press event for the held key on the first cycle after reset.

Source files
------------

// File: rtl/keycode_event_queue.sv
// Turns the SoC keycode level and raw pushbuttons into press/release events,
// queued in a first-word-fall-through FIFO with a valid/ready handshake.
module keycode_event_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [7:0]                    keycode,
  input  logic [3:0]                    button_n,
  output logic [9:0]                    ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic [3:0]                    buttons_db,
  output logic [7:0]                    cur_key,
  output logic                          overflow
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AddrW:0]  Full   = (AddrW + 1)'(FIFO_DEPTH);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       db_q, db_d;
  logic [CntW-1:0]  cnt_q [4];
  logic [CntW-1:0]  cnt_d [4];
  logic [3:0]       rep_q, rep_d;
  logic [7:0]       cur_key_q, cur_key_d;
  logic             overflow_q, overflow_d;

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;

  logic             pending, push, pop, full, found;
  logic [9:0]       ev_word;
  logic [7:0]       key_cand;
  logic [3:0]       rep_cand;

  // Debounce: a button level is accepted only after it differs for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Event selection: key release, then key press, then lowest-index button change.
  always_comb begin
    pending  = 1'b0;
    found    = 1'b0;
    ev_word  = '0;
    key_cand = cur_key_q;
    rep_cand = rep_q;
    if (keycode != cur_key_q) begin
      pending = 1'b1;
      if (cur_key_q != 8'h00) begin
        ev_word  = {2'b01, cur_key_q};
        key_cand = 8'h00;
      end else begin
        ev_word  = {2'b00, keycode};
        key_cand = keycode;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!found && (db_q[i] != rep_q[i])) begin
          found       = 1'b1;
          pending     = 1'b1;
          ev_word     = {1'b1, ~db_q[i], 6'b0, 2'(i)};
          rep_cand[i] = db_q[i];
        end
      end
    end
  end

  // Fullness uses the registered count, so a same-cycle pop cannot make room.
  always_comb begin
    full       = (count_q == Full);
    push       = pending && !full;
    pop        = (count_q != '0) && ev_ready;
    cur_key_d  = push ? key_cand : cur_key_q;
    rep_d      = push ? rep_cand : rep_q;
    overflow_d = overflow_q | (pending && full);
    wr_ptr_d   = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AddrW + 1)'(1);
      2'b01:   count_d = count_q - (AddrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      rep_q      <= '0;
      cur_key_q  <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q    <= ~button_n;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      rep_q      <= rep_d;
      cur_key_q  <= cur_key_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      if (push) mem_q[wr_ptr_q] <= ev_word;
    end
  end

  assign ev_data    = mem_q[rd_ptr_q];
  assign ev_valid   = (count_q != '0);
  assign ev_count   = count_q;
  assign buttons_db = db_q;
  assign cur_key    = cur_key_q;
  assign overflow   = overflow_q;

endmodule
